booth_div_16_16: RTL and testbench

Sequential 16-bit by 16-bit integer divider, the inverse-operation companion to the Booth-4/Wallace 16x16 multiplier. It sits beside the multiplier in the arithmetic unit and takes operands through a valid/ready handshake. It runs a radix-2 non-restoring iteration, one quotient bit per clock, and returns quotient and remainder through a second valid/ready handshake. One division is in flight at a time.

---
 rtl/booth_div_16_16_pkg.sv | 23 ++
 rtl/booth_div_16_16_if.sv | 27 ++
 rtl/booth_div_16_16_div_nr_step.sv | 23 ++
 rtl/booth_div_16_16.sv | 177 +++++++++++++++++
 tb/tb_booth_div_16_16.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/booth_div_16_16_pkg.sv
// Shared definitions for the radix-2 non-restoring 16/16 divider:
// state encodings, operand width, iteration counter width and a small negate helper.
package booth_div_16_16_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 5;

    // Counter value seen during the final CALC cycle
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                   input logic              neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/booth_div_16_16_if.sv
// Operand/result handshake bundle for booth_div_16_16.
// master = operand producer / result consumer, slave = the divider.
interface booth_div_16_16_if;
    import booth_div_16_16_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
    logic              is_signed;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;
    logic              div_by_zero;

    modport master (
        output in_valid, dividend, divisor, is_signed, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, is_signed, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/booth_div_16_16_div_nr_step.sv
// One combinational non-restoring iteration: shift in the next dividend bit,
// add or subtract the divisor depending on the sign of the old partial remainder.
module booth_div_16_16_div_nr_step
    import booth_div_16_16_pkg::*;
(
    input  logic [DATA_W:0]   p,
    input  logic              bit_in,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W:0]   p_next,
    output logic              q_bit
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] d_ext;

    // P stays within [-D, D), so dropping the old sign bit in the shift is safe:
    // the add/subtract decision uses it and the result fits back into 17 bits.
    assign shifted = {p[DATA_W-1:0], bit_in};
    assign d_ext   = {1'b0, d};
    assign p_next  = p[DATA_W] ? (shifted + d_ext) : (shifted - d_ext);
    assign q_bit   = ~p_next[DATA_W];

endmodule

// File: rtl/booth_div_16_16.sv
// Sequential 16/16 divider, one quotient bit per clock, valid/ready in and out.
// Define DIV_SIGNED_EN to build two's-complement support (is_signed honoured).
//
//  state | meaning
//  IDLE  | in_ready high, waiting for operands
//  CALC  | 16 non-restoring iterations
//  FIX   | remainder correction, sign fix-up, result register load
//  DONE  | out_valid high, result held until out_ready
module booth_div_16_16
    import booth_div_16_16_pkg::*;
(
    input logic              sys_clk,
    input logic              sys_rst,
    booth_div_16_16_if.slave bus
);

    div_state_t        state_q;
    div_state_t        state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W:0]   p_q;
    logic [DATA_W:0]   p_step;
    logic [DATA_W-1:0] q_q;
    logic [DATA_W-1:0] d_q;
    logic              q_bit;
    logic              zero_q;
    logic [DATA_W-1:0] quot_q;
    logic [DATA_W-1:0] rem_q;
    logic              dbz_q;

    logic              accept;
    logic              in_ready_c;
    logic              out_valid_c;
    logic              divisor_zero;
    logic [DATA_W-1:0] dvd_op;
    logic [DATA_W-1:0] dvs_op;
    logic [DATA_W-1:0] rem_mag;
    logic [DATA_W-1:0] quot_fix;
    logic [DATA_W-1:0] rem_fix;

    assign divisor_zero = (bus.divisor == '0);
    assign accept       = bus.in_valid & in_ready_c;

    assign rem_mag = p_q[DATA_W] ? (p_q[DATA_W-1:0] + d_q) : p_q[DATA_W-1:0];

`ifdef DIV_SIGNED_EN
    logic dvd_neg;
    logic dvs_neg;
    logic q_neg_q;
    logic r_neg_q;

    assign dvd_neg = bus.is_signed & bus.dividend[DATA_W-1];
    assign dvs_neg = bus.is_signed & bus.divisor[DATA_W-1];

    // A zero divisor returns the raw dividend as remainder, so keep it unconverted
    assign dvd_op = cond_neg(bus.dividend, dvd_neg & ~divisor_zero);
    assign dvs_op = cond_neg(bus.divisor, dvs_neg);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (accept) begin
            q_neg_q <= dvd_neg ^ dvs_neg;
            r_neg_q <= dvd_neg;
        end
    end

    assign quot_fix = cond_neg(q_q, q_neg_q);
    assign rem_fix  = cond_neg(rem_mag, r_neg_q);
`else
    logic unused_is_signed;

    assign unused_is_signed = bus.is_signed;
    assign dvd_op           = bus.dividend;
    assign dvs_op           = bus.divisor;
    assign quot_fix         = q_q;
    assign rem_fix          = rem_mag;
`endif

    booth_div_16_16_div_nr_step u_step (
        .p      (p_q),
        .bit_in (q_q[DATA_W-1]),
        .d      (d_q),
        .p_next (p_step),
        .q_bit  (q_bit)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A zero divisor still passes through FIX so its result lands one edge after accept
    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_d = divisor_zero ? FIX : CALC;
                end
            end
            CALC: begin
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q  <= '0;
            p_q    <= '0;
            q_q    <= '0;
            d_q    <= '0;
            zero_q <= 1'b0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt_q  <= '0;
                        p_q    <= '0;
                        q_q    <= dvd_op;
                        d_q    <= dvs_op;
                        zero_q <= divisor_zero;
                        dbz_q  <= 1'b0;
                    end
                end
                CALC: begin
                    p_q   <= p_step;
                    q_q   <= {q_q[DATA_W-2:0], q_bit};
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                FIX: begin
                    if (zero_q) begin
                        quot_q <= '1;
                        rem_q  <= q_q;
                        dbz_q  <= 1'b1;
                    end else begin
                        quot_q <= quot_fix;
                        rem_q  <= rem_fix;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = out_valid_c;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_booth_div_16_16.sv
// Scoreboard bench for booth_div_16_16: expected results queued at drive time,
// popped and compared when out_valid rises.
module tb_booth_div_16_16;
    import booth_div_16_16_pkg::*;

    typedef struct {
        logic [DATA_W-1:0] q;
        logic [DATA_W-1:0] r;
        logic              dbz;
        int                lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    booth_div_16_16_if bus();

    booth_div_16_16 dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sgn);
        exp_t e;
        logic use_sgn;
        int   sa;
        int   sd;
`ifdef DIV_SIGNED_EN
        use_sgn = sgn;
`else
        use_sgn = sgn & 1'b0;
`endif
        e.dbz = (b == 16'd0);
        e.lat = (b == 16'd0) ? 1 : 17;
        if (b == 16'd0) begin
            e.q = 16'hFFFF;
            e.r = a;
        end else if (use_sgn) begin
            sa  = int'($signed(a));
            sd  = int'($signed(b));
            e.q = 16'(sa / sd);
            e.r = 16'(sa % sd);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sgn);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.in_ready !== 1'b1) chk("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.is_signed = sgn;
        sb.push_back(model(a, b, sgn));
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.dividend  = 16'($urandom);
        bus.divisor   = 16'($urandom);
        bus.is_signed = 1'($urandom);
    endtask

    task automatic collect(input string tag);
        exp_t e;
        int   edges = 0;
        while (bus.out_valid !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_lat"}, edges, e.lat);
        chk({tag, "_quot"}, {16'd0, bus.quotient}, {16'd0, e.q});
        chk({tag, "_rem"}, {16'd0, bus.remainder}, {16'd0, e.r});
        chk({tag, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
    endtask

    // out_ready is high: result is taken on the next edge, in_ready returns with it
    task automatic consume(input string tag);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_idle"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b, input logic sgn);
        send(a, b, sgn);
        collect(tag);
        consume(tag);
    endtask

    task automatic count_valid(input int cycles, output int hits);
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) hits++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] hq;
        logic [15:0] hr;
        logic        hd;
        int          bad;
        int          hits;

        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.is_signed = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_quot", {16'd0, bus.quotient}, 32'd0);
        chk("rst_rem", {16'd0, bus.remainder}, 32'd0);
        chk("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run("u_1000_7", 16'd1000, 16'd7, 1'b0);
        run("u_dbz", 16'h1234, 16'h0000, 1'b0);
        run("u_ffff_1", 16'hFFFF, 16'd1, 1'b0);
        run("s_m100_7", 16'hFF9C, 16'd7, 1'b1);
        run("s_100_m7", 16'd100, 16'hFFF9, 1'b1);
        run("s_dbz", 16'h1234, 16'h0000, 1'b1);
        run("s_ovf", 16'h8000, 16'hFFFF, 1'b1);
        run("u_small_big", 16'd5, 16'd9, 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            a = 16'($urandom);
            b = (i % 2 == 0) ? 16'($urandom_range(1, 300)) : 16'($urandom_range(1, 65535));
            run($sformatf("rnd%0d", i), a, b, 1'($urandom_range(0, 1)));
        end

        // Back-pressure: result held, in_ready low, extra in_valid ignored
        bus.out_ready = 1'b0;
        send(16'd300, 16'd9, 1'b0);
        collect("bp");
        hq  = bus.quotient;
        hr  = bus.remainder;
        hd  = bus.div_by_zero;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = (i >= 2 && i < 6);
            bus.dividend = 16'd77;
            bus.divisor  = 16'd1;
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quotient !== hq ||
                bus.remainder !== hr || bus.div_by_zero !== hd) bad++;
        end
        chk("bp_stable", bad, 32'd0);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
        count_valid(25, hits);
        chk("bp_no_extra", hits, 32'd0);

        // Reset in the middle of the iteration
        send(16'd1000, 16'd7, 1'b0);
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("mrst_quot", {16'd0, bus.quotient}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        count_valid(25, hits);
        chk("mrst_no_pulse", hits, 32'd0);
        run("post_rst_50_5", 16'd50, 16'd5, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
